uart_axil_regs: RTL and testbench
=================================

UART_AXIL_REGS -- requirements
Module: uart_axil_regs

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, gives the entries per TX and RX FIFO; it SHALL be a power of two between 2 and 64.
REQ-002 chipset_clk  in  1  sole clock; all logic is rising-edge.
REQ-003 chipset_rst_n  in  1  asynchronous active-low reset.
REQ-004 uart_axi_awaddr  in  13, uart_axi_awvalid  in  1, uart_axi_awready  out  1: AXI4-Lite write address.
REQ-005 uart_axi_wdata  in  32, uart_axi_wstrb  in  4, uart_axi_wvalid  in  1, uart_axi_wready  out  1: write data.
REQ-006 uart_axi_bresp  out  2, uart_axi_bvalid  out  1, uart_axi_bready  in  1: write response.
REQ-007 uart_axi_araddr  in  13, uart_axi_arvalid  in  1, uart_axi_arready  out  1: read address.
REQ-008 uart_axi_rdata  out  32, uart_axi_rresp  out  2, uart_axi_rvalid  out  1, uart_axi_rready  in  1: read data.
REQ-009 tx_data  out  8, tx_valid  out  1, tx_ready  in  1: byte stream to the serializer.
REQ-010 rx_data  in  8, rx_valid  in  1, rx_ready  out  1: byte stream from the deserializer.
REQ-011 uart_irq  out  1: level interrupt.

Function
REQ-012 The register map SHALL decode awaddr/araddr[3:2] as follows: 0x0 RXFIFO (read-only), 0x4 TXFIFO (write-only), 0x8 STAT (read-only), 0xC CTRL (write-only).
- Bits [12:4] SHALL be ignored (aliasing).
- Reads of write-only registers SHALL return 0.
- Writes to read-only registers SHALL be ignored.
- bresp and rresp SHALL always be OKAY (2'b00).
REQ-013 Write handshake: awready and wready SHALL both assert combinationally in the same cycle only when awvalid & wvalid & !bvalid; the write takes effect on that edge.
- bvalid SHALL rise on the next cycle and hold until bready.
REQ-014 Read handshake: arready SHALL equal !rvalid.
- On an accepted read, rvalid and rdata SHALL be registered on the next cycle and held stable until rready.
REQ-015 TXFIFO write with wstrb[0]=1 SHALL push wdata[7:0].
- If the FIFO is full, the byte SHALL be dropped and STAT[6] (overrun) set.
- wstrb[0]=0 SHALL be ignored.
REQ-016 RXFIFO read SHALL pop and return the head byte in rdata[7:0], with upper bits zero.
- If the FIFO is empty, the read SHALL return 0 with no pop.
REQ-017 STAT bits SHALL be:
- [0] RX non-empty
- [1] RX full
- [2] TX empty
- [3] TX full
- [4] interrupt enable
- [6] TX overrun (sticky)
- all other bits 0.
- Reading STAT SHALL clear bit 6 on the accept edge; a drop in the same cycle SHALL win, leaving bit 6 set.
REQ-018 CTRL write with wstrb[0]=1 SHALL act as follows:
- bit0 flushes TX FIFO
- bit1 flushes RX FIFO
- bit4 loads interrupt enable.
- A flush SHALL override a push or pop on the same edge.
REQ-019 tx_valid SHALL equal TX non-empty, with tx_data the TX head; tx_valid & tx_ready pops one entry per cycle.
REQ-020 rx_ready SHALL equal RX not-full; rx_valid & rx_ready pushes rx_data.
REQ-021 A simultaneous push and pop on either FIFO SHALL keep the count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
- The count is log2(FIFO_DEPTH)+1 bits.
REQ-022 Throughput: one outstanding write and one outstanding read; the read and write channels SHALL operate independently in the same cycle.

Reset
REQ-023 While chipset_rst_n=0, the block SHALL hold:
- FIFOs empty, pointers 0, overrun 0, interrupt enable 0
- awready, wready, arready, bvalid, rvalid, tx_valid, uart_irq 0
- rx_ready 0; rx_ready SHALL rise one cycle after reset release
- rdata, bresp, rresp 0.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no partial state retained.

Configuration
REQ-025 With UART_AXIL_IRQ_EN defined, uart_irq SHALL be registered and SHALL equal interrupt enable & (RX non-empty | TX empty), one cycle after the state change.
REQ-026 Without UART_AXIL_IRQ_EN, uart_irq SHALL be constant 0, STAT[4] SHALL read 0, and CTRL bit4 SHALL be ignored.

Verification
REQ-027 Write 0x41 to 0x4 with tx_ready=0 -> bvalid one cycle after the handshake, tx_valid=1, tx_data=0x41, STAT[2]=0.
REQ-028 Push 17 TX bytes with tx_ready=0 -> 17th byte dropped, STAT reads 0x48, then a second STAT read returns 0x08.
REQ-029 Drive rx_data=0x5A with rx_valid for 16 cycles -> rx_ready=0 after the 16th byte; STAT=0x03; 16 reads of 0x0 return 0x5A; a 17th read returns 0.
REQ-030 With UART_AXIL_IRQ_EN, write 0x10 to 0xC with TX empty -> uart_irq=1 on the next cycle; write 0x00 -> uart_irq=0.
REQ-031 Write 0x03 to 0xC while the TX and RX FIFOs hold data and tx_ready=1 -> both empty next cycle, STAT=0x04.
REQ-032 Drop chipset_rst_n while bvalid=1 and bready=0 -> bvalid=0 immediately, and all outputs match REQ-023.

Source files
------------

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front end for a UART: TX/RX byte FIFOs, status and control.
// Define UART_AXIL_IRQ_EN to build the registered level interrupt and its enable bit.
module uart_axil_regs #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        chipset_clk,
  input  logic        chipset_rst_n,
  input  logic [12:0] uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic [3:0]  uart_axi_wstrb,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic [12:0] uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        uart_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic          r_bvalid;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic          r_alive;
  logic          r_ovr;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp;
  logic [AW-1:0] r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wp;
  logic [AW-1:0] r_rx_rp;
  logic [CW-1:0] r_rx_cnt;

  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_wr_tx;
  logic        w_wr_ctrl;
  logic        w_ar_rx;
  logic        w_ar_st;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_ne;
  logic        w_tx_push;
  logic        w_tx_drop;
  logic        w_tx_pop;
  logic        w_tx_flush;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_flush;
  logic        w_ie;
  logic [31:0] w_stat;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_ne    = (r_rx_cnt != '0);

  // Handshakes are gated by reset directly so they read 0 while held.
  assign w_wr_en = chipset_rst_n & uart_axi_awvalid
                 & uart_axi_wvalid & ~r_bvalid;
  assign uart_axi_awready = w_wr_en;
  assign uart_axi_wready  = w_wr_en;
  assign uart_axi_arready = chipset_rst_n & ~r_rvalid;
  assign w_rd_en = uart_axi_arvalid & uart_axi_arready;

  assign w_wr_tx   = w_wr_en & uart_axi_wstrb[0]
                   & (uart_axi_awaddr[3:2] == 2'd1);
  assign w_wr_ctrl = w_wr_en & uart_axi_wstrb[0]
                   & (uart_axi_awaddr[3:2] == 2'd3);
  assign w_ar_rx   = (uart_axi_araddr[3:2] == 2'd0);
  assign w_ar_st   = (uart_axi_araddr[3:2] == 2'd2);

  assign w_tx_push  = w_wr_tx & ~w_tx_full;
  assign w_tx_drop  = w_wr_tx & w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & tx_ready;
  assign w_tx_flush = w_wr_ctrl & uart_axi_wdata[0];
  assign w_rx_push  = rx_valid & rx_ready;
  assign w_rx_pop   = w_rd_en & w_ar_rx & w_rx_ne;
  assign w_rx_flush = w_wr_ctrl & uart_axi_wdata[1];

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = r_tx_mem[r_tx_rp];
  assign rx_ready = r_alive & ~w_rx_full;

  assign uart_axi_bvalid = r_bvalid;
  assign uart_axi_rvalid = r_rvalid;
  assign uart_axi_rdata  = r_rdata;
  assign uart_axi_bresp  = 2'b00;
  assign uart_axi_rresp  = 2'b00;

  assign w_stat = {25'd0, r_ovr, 1'b0, w_ie, w_tx_full,
                   w_tx_empty, w_rx_full, w_rx_ne};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_ar_rx: w_rdata = w_rx_ne ? {24'd0, r_rx_mem[r_rx_rp]} : '0;
      w_ar_st: w_rdata = w_stat;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_alive  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_wr_en)
        r_bvalid <= 1'b1;
      else if (uart_axi_bready)
        r_bvalid <= 1'b0;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (uart_axi_rready) begin
        r_rvalid <= 1'b0;
      end
      // A drop on the same edge as a STAT read keeps the flag.
      if (w_tx_drop)
        r_ovr <= 1'b1;
      else if (w_rd_en && w_ar_st)
        r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge chipset_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= uart_axi_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
  end

`ifdef UART_AXIL_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ie <= uart_axi_wdata[4];
      r_irq <= r_ie & (w_rx_ne | w_tx_empty);
    end
  end

  assign w_ie     = r_ie;
  assign uart_irq = r_irq;
`else
  assign w_ie     = 1'b0;
  assign uart_irq = 1'b0;
`endif

  assign w_unused = &{1'b0, uart_axi_awaddr[12:4],
                      uart_axi_awaddr[1:0], uart_axi_wdata[31:8],
                      uart_axi_wstrb[3:1], uart_axi_araddr[12:4],
                      uart_axi_araddr[1:0]};

endmodule

// File: tb/tb_uart_axil_regs.sv
// Randomized bench for uart_axil_regs against a queue-based register model.
// Directed sequences pin the model with literal expected values.
module tb_uart_axil_regs;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [12:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  always #5 clk = ~clk;

  uart_axil_regs #(.FIFO_DEPTH(D)) dut (
    .chipset_clk(clk),
    .chipset_rst_n(rst_n),
    .uart_axi_awaddr(awaddr),
    .uart_axi_awvalid(awvalid),
    .uart_axi_awready(awready),
    .uart_axi_wdata(wdata),
    .uart_axi_wstrb(wstrb),
    .uart_axi_wvalid(wvalid),
    .uart_axi_wready(wready),
    .uart_axi_bresp(bresp),
    .uart_axi_bvalid(bvalid),
    .uart_axi_bready(bready),
    .uart_axi_araddr(araddr),
    .uart_axi_arvalid(arvalid),
    .uart_axi_arready(arready),
    .uart_axi_rdata(rdata),
    .uart_axi_rresp(rresp),
    .uart_axi_rvalid(rvalid),
    .uart_axi_rready(rready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .uart_irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_bvalid;
  bit          m_rvalid;
  bit          m_ovr;
  bit          m_ie;
  bit          m_irq;
  bit          m_alive;
  bit          m_wacc;
  bit          m_racc;
  logic [31:0] m_rdata;

  task automatic cmpb(string n, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b exp %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic cmpw(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s = '0;
    s[0] = (rxq.size() != 0);
    s[1] = (rxq.size() == D);
    s[2] = (txq.size() == 0);
    s[3] = (txq.size() == D);
    s[4] = m_ie;
    s[6] = m_ovr;
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_bvalid = 0;
    m_rvalid = 0;
    m_ovr = 0;
    m_ie = 0;
    m_irq = 0;
    m_alive = 0;
    m_wacc = 0;
    m_racc = 0;
    m_rdata = '0;
  endtask

  // Advance the model by one rising edge using the inputs held at that edge.
  task automatic model_step();
    bit wr, rd, ctrl, txpush, drop, txpop, rxpush, rxpop;
    logic [31:0] st;
    if (!rst_n) begin
      model_reset();
      return;
    end
    st = m_stat();
`ifdef UART_AXIL_IRQ_EN
    m_irq = m_ie && (rxq.size() != 0 || txq.size() == 0);
`endif
    wr = awvalid && wvalid && !m_bvalid;
    rd = arvalid && !m_rvalid;
    rxpop = 0;
    if (rd) begin
      m_rvalid = 1;
      m_rdata = '0;
      if (araddr[3:2] == 2'd0 && rxq.size() != 0) begin
        m_rdata = {24'd0, rxq[0]};
        rxpop = 1;
      end
      if (araddr[3:2] == 2'd2) m_rdata = st;
    end else if (m_rvalid && rready) begin
      m_rvalid = 0;
    end
    if (wr) m_bvalid = 1;
    else if (m_bvalid && bready) m_bvalid = 0;
    txpush = wr && awaddr[3:2] == 2'd1 && wstrb[0] && txq.size() < D;
    drop = wr && awaddr[3:2] == 2'd1 && wstrb[0] && txq.size() == D;
    ctrl = wr && awaddr[3:2] == 2'd3 && wstrb[0];
    txpop = txq.size() != 0 && tx_ready;
    rxpush = m_alive && rxq.size() < D && rx_valid;
    if (ctrl && wdata[0]) txq.delete();
    else begin
      if (txpop) void'(txq.pop_front());
      if (txpush) txq.push_back(wdata[7:0]);
    end
    if (ctrl && wdata[1]) rxq.delete();
    else begin
      if (rxpop) void'(rxq.pop_front());
      if (rxpush) rxq.push_back(rx_data);
    end
    if (drop) m_ovr = 1;
    else if (rd && araddr[3:2] == 2'd2) m_ovr = 0;
`ifdef UART_AXIL_IRQ_EN
    if (ctrl) m_ie = wdata[4];
`endif
    m_alive = 1;
    m_wacc = wr;
    m_racc = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    cmpb("awready", awready, rst_n & awvalid & wvalid & !m_bvalid);
    cmpb("wready", wready, rst_n & awvalid & wvalid & !m_bvalid);
    cmpb("arready", arready, rst_n & !m_rvalid);
    cmpb("bvalid", bvalid, m_bvalid);
    cmpb("rvalid", rvalid, m_rvalid);
    cmpw("rdata", rdata, m_rdata);
    cmpw("bresp", 32'(bresp), 32'd0);
    cmpw("rresp", 32'(rresp), 32'd0);
    cmpb("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) cmpw("tx_data", 32'(tx_data), 32'(txq[0]));
    cmpb("rx_ready", rx_ready, rst_n && m_alive && rxq.size() < D);
    cmpb("irq", irq, m_irq);
  end

  task automatic axi_write(logic [12:0] a, logic [31:0] d, logic [3:0] s);
    int n;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1;
    wvalid = 1;
    bready = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_wacc && n < 50);
    if (!m_wacc) begin
      errors++;
      $display("FAIL write_timeout addr %h", a);
    end
    awvalid = 0;
    wvalid = 0;
    cmpb("bvalid_after_wr", bvalid, 1'b1);
    tick();
    bready = 0;
  endtask

  task automatic axi_read(logic [12:0] a, output logic [31:0] d);
    int n;
    araddr = a;
    arvalid = 1;
    rready = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_racc && n < 50);
    if (!m_racc) begin
      errors++;
      $display("FAIL read_timeout addr %h", a);
    end
    arvalid = 0;
    cmpb("rvalid_after_rd", rvalid, 1'b1);
    d = rdata;
    tick();
    rready = 0;
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    awvalid = 1;
    wvalid = 1;
    arvalid = 1;
    rx_valid = 1;
    repeat (3) tick();
    cmpb("rst_awready", awready, 1'b0);
    cmpb("rst_arready", arready, 1'b0);
    cmpb("rst_rx_ready", rx_ready, 1'b0);
    cmpb("rst_tx_valid", tx_valid, 1'b0);
    awvalid = 0;
    wvalid = 0;
    arvalid = 0;
    rx_valid = 0;
    rst_n = 1;
    #1;
    cmpb("rx_ready_release", rx_ready, 1'b0);
    tick();
    cmpb("rx_ready_after", rx_ready, 1'b1);

    tx_ready = 0;
    axi_write(13'h004, 32'h0000_0041, 4'h1);
    cmpb("tx_valid_41", tx_valid, 1'b1);
    cmpw("tx_data_41", 32'(tx_data), 32'h41);
    axi_read(13'h008, d);
    cmpw("stat_one_tx", d, 32'h00);

    for (int i = 1; i < 16; i++) axi_write(13'h004, 32'(i), 4'h1);
    axi_write(13'h1F4, 32'h0000_00EE, 4'h1);
    axi_write(13'h004, 32'h0000_0099, 4'h0);
    axi_read(13'h008, d);
    cmpw("stat_overrun", d, 32'h48);
    axi_read(13'h008, d);
    cmpw("stat_ovr_clr", d, 32'h08);
    cmpw("tx_head_kept", 32'(tx_data), 32'h41);
    axi_read(13'h004, d);
    cmpw("read_txfifo", d, 32'h0);
    tx_ready = 1;
    repeat (17) tick();
    cmpb("tx_drained", tx_valid, 1'b0);
    axi_read(13'h008, d);
    cmpw("stat_idle", d, 32'h04);

    tx_ready = 0;
    axi_write(13'h004, 32'h11, 4'h1);
    rx_data = 8'h5A;
    rx_valid = 1;
    repeat (16) tick();
    rx_valid = 0;
    cmpb("rx_full_ready", rx_ready, 1'b0);
    axi_read(13'h008, d);
    cmpw("stat_rx_full", d, 32'h03);
    for (int i = 0; i < 16; i++) begin
      axi_read(13'h000, d);
      cmpw("rx_pop_5a", d, 32'h5A);
    end
    axi_read(13'h100, d);
    cmpw("rx_empty_read", d, 32'h0);

    axi_write(13'h004, 32'h22, 4'h1);
    axi_write(13'h004, 32'h33, 4'h1);
    rx_valid = 1;
    rx_data = 8'hC3;
    repeat (3) tick();
    rx_valid = 0;
    tx_ready = 1;
    axi_write(13'h00C, 32'h03, 4'h1);
    cmpb("flush_tx", tx_valid, 1'b0);
    axi_read(13'h008, d);
    cmpw("stat_flushed", d, 32'h04);

`ifdef UART_AXIL_IRQ_EN
    axi_write(13'h00C, 32'h10, 4'h1);
    cmpb("irq_on", irq, 1'b1);
    axi_write(13'h00C, 32'h00, 4'h1);
    cmpb("irq_off", irq, 1'b0);
`else
    axi_write(13'h00C, 32'h10, 4'h1);
    axi_read(13'h008, d);
    cmpw("stat_no_ie", d, 32'h04);
    cmpb("irq_const", irq, 1'b0);
`endif

    for (int c = 0; c < 4000; c++) begin
      bit slow;
      slow = ((c / 400) % 2) == 1;
      awaddr = 13'($urandom);
      awvalid = $urandom_range(0, 1) == 1;
      wvalid = $urandom_range(0, 3) != 0;
      wstrb = 4'($urandom);
      wdata = $urandom;
      if (awaddr[3:2] == 2'd3 && $urandom_range(0, 7) != 0)
        wdata[1:0] = 2'b00;
      bready = $urandom_range(0, 2) != 0;
      araddr = 13'($urandom);
      arvalid = $urandom_range(0, 1) == 1;
      rready = $urandom_range(0, 2) != 0;
      tx_ready = slow ? ($urandom_range(0, 5) == 0)
                      : ($urandom_range(0, 1) == 1);
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data = 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
      end
      tick();
    end

    awvalid = 0;
    wvalid = 0;
    arvalid = 0;
    rx_valid = 0;
    tx_ready = 0;
    bready = 1;
    rready = 1;
    tick();
    tick();
    bready = 0;
    awaddr = 13'h004;
    wdata = 32'h77;
    wstrb = 4'h1;
    awvalid = 1;
    wvalid = 1;
    tick();
    awvalid = 0;
    wvalid = 0;
    tick();
    cmpb("bvalid_held", bvalid, 1'b1);
    #2;
    awvalid = 1;
    wvalid = 1;
    rst_n = 0;
    model_reset();
    #1;
    cmpb("rst_bvalid", bvalid, 1'b0);
    cmpb("rst_wready", wready, 1'b0);
    cmpb("rst_rvalid", rvalid, 1'b0);
    cmpw("rst_rdata", rdata, 32'h0);
    cmpb("rst_tx_valid2", tx_valid, 1'b0);
    cmpb("rst_rx_ready2", rx_ready, 1'b0);
    cmpb("rst_irq", irq, 1'b0);
    tick();
    awvalid = 0;
    wvalid = 0;
    rst_n = 1;
    tick();
    axi_read(13'h008, d);
    cmpw("stat_after_rst", d, 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
